// File: rtl/rtc_bus_sched.sv
// rtl/rtc_bus_sched.sv - RTC multiplexed-bus scheduler: periodic register sweep plus PicoBlaze writes
//
// Optional build macro: RTC_SNAPSHOT_EN (stage sweep reads, publish all shadows on sweep_done)
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   wr_req, wr_addr, wr_data      one-cycle write request from PicoBlaze port logic
//   wr_busy, wr_overrun           write pending/in progress; sticky dropped-request flag
//   rtc_cs_n, rtc_ad_sel          chip select, 1 = address phase / 0 = data phase
//   rtc_rd_n, rtc_wr_n            read / write strobes
//   rtc_ad_out, rtc_ad_oe         bus drive value and output enable
//   rtc_ad_in                     bus sample value
//   seg..chora                    shadow registers for the PicoBlaze input mux
//   sweep_done                    one-cycle pulse at the end of a full sweep
module rtc_bus_sched #(
  parameter int T_PHASE        = 4,
  parameter int REFRESH_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_busy,
  output logic       wr_overrun,
  output logic       rtc_cs_n,
  output logic       rtc_ad_sel,
  output logic       rtc_rd_n,
  output logic       rtc_wr_n,
  output logic [7:0] rtc_ad_out,
  output logic       rtc_ad_oe,
  input  logic [7:0] rtc_ad_in,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] ano,
  output logic [7:0] cseg,
  output logic [7:0] cmin,
  output logic [7:0] chora,
  output logic       sweep_done
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_GAP1, S_DATA, S_GAP2} state_t;

  state_t      state, state_nx;
  logic [3:0]  ph_cnt;
  logic        ph_last;
  logic [15:0] refresh_cnt;
  logic        refresh_wrap;
  logic        sweep_pending, sweep_active;
  logic [3:0]  sweep_idx;
  logic        wr_pending, txn_is_wr;
  logic [7:0]  wr_addr_q, wr_data_q;
  logic        start_wr, start_rd, txn_end, rd_sample, sweep_last;
  logic [7:0]  cur_addr;
  logic [7:0]  shd [9];

  function automatic logic [7:0] sweep_addr(input logic [3:0] i);
    case (i)
      4'd0:    sweep_addr = 8'h21;
      4'd1:    sweep_addr = 8'h22;
      4'd2:    sweep_addr = 8'h23;
      4'd3:    sweep_addr = 8'h24;
      4'd4:    sweep_addr = 8'h25;
      4'd5:    sweep_addr = 8'h26;
      4'd6:    sweep_addr = 8'h41;
      4'd7:    sweep_addr = 8'h42;
      4'd8:    sweep_addr = 8'h43;
      default: sweep_addr = 8'h00;
    endcase
  endfunction

  assign ph_last      = (ph_cnt == 4'(T_PHASE - 1));
  assign refresh_wrap = (refresh_cnt == 16'(REFRESH_CYCLES - 1));
  assign txn_end      = (state == S_GAP2) && ph_last;
  assign rd_sample    = (state == S_DATA) && ph_last && !txn_is_wr;
  assign sweep_last   = txn_end && !txn_is_wr && (sweep_idx == 4'd8);
  assign cur_addr     = txn_is_wr ? wr_addr_q : sweep_addr(sweep_idx);

  // Writes win arbitration, but only here in IDLE, so a sweep is never cut mid-transaction.
  always_comb begin
    state_nx = state;
    start_wr = 1'b0;
    start_rd = 1'b0;
    case (state)
      S_IDLE: begin
        if (wr_pending) begin
          start_wr = 1'b1;
          state_nx = S_ADDR;
        end else if (sweep_active || sweep_pending) begin
          start_rd = 1'b1;
          state_nx = S_ADDR;
        end
      end
      S_ADDR:  if (ph_last) state_nx = S_GAP1;
      S_GAP1:  if (ph_last) state_nx = S_DATA;
      S_DATA:  if (ph_last) state_nx = S_GAP2;
      S_GAP2:  if (ph_last) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Bus pins decode straight from the state register so an async reset releases them at once.
  always_comb begin
    rtc_cs_n   = 1'b1;
    rtc_ad_sel = 1'b0;
    rtc_rd_n   = 1'b1;
    rtc_wr_n   = 1'b1;
    rtc_ad_oe  = 1'b0;
    rtc_ad_out = 8'h00;
    case (state)
      S_ADDR: begin
        rtc_cs_n   = 1'b0;
        rtc_ad_sel = 1'b1;
        rtc_wr_n   = 1'b0;
        rtc_ad_oe  = 1'b1;
        rtc_ad_out = cur_addr;
      end
      S_DATA: begin
        rtc_cs_n = 1'b0;
        if (txn_is_wr) begin
          rtc_wr_n   = 1'b0;
          rtc_ad_oe  = 1'b1;
          rtc_ad_out = wr_data_q;
        end else begin
          rtc_rd_n = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      ph_cnt <= 4'd0;
    end else begin
      state  <= state_nx;
      ph_cnt <= (state == S_IDLE || ph_last) ? 4'd0 : ph_cnt + 4'd1;
    end
  end

  // wr_busy trails wr_pending by one cycle on the falling side, so a request in the
  // cycle right after the write finishes is still treated as busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_pending <= 1'b0;
      wr_busy    <= 1'b0;
      wr_overrun <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
      txn_is_wr  <= 1'b0;
    end else begin
      wr_busy <= wr_pending || (wr_req && !wr_busy);
      if (wr_req && wr_busy) wr_overrun <= 1'b1;
      if (wr_req && !wr_busy) begin
        wr_pending <= 1'b1;
        wr_addr_q  <= wr_addr;
        wr_data_q  <= wr_data;
      end else if (txn_end && txn_is_wr) begin
        wr_pending <= 1'b0;
      end
      if (start_wr)      txn_is_wr <= 1'b1;
      else if (start_rd) txn_is_wr <= 1'b0;
    end
  end

  // Index 0 is only ever started as the first read of a new sweep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh_cnt   <= 16'd0;
      sweep_pending <= 1'b0;
      sweep_active  <= 1'b0;
      sweep_idx     <= 4'd0;
      sweep_done    <= 1'b0;
    end else begin
      refresh_cnt <= refresh_wrap ? 16'd0 : refresh_cnt + 16'd1;
      if (refresh_wrap)                          sweep_pending <= 1'b1;
      else if (start_rd && sweep_idx == 4'd0)    sweep_pending <= 1'b0;
      if (start_rd && sweep_idx == 4'd0)         sweep_active  <= 1'b1;
      else if (sweep_last)                       sweep_active  <= 1'b0;
      if (txn_end && !txn_is_wr)
        sweep_idx <= (sweep_idx == 4'd8) ? 4'd0 : sweep_idx + 4'd1;
      sweep_done <= sweep_last;
    end
  end

`ifdef RTC_SNAPSHOT_EN
  logic [7:0] stage [9];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 9; i++) begin
        stage[i] <= 8'h00;
        shd[i]   <= 8'h00;
      end
    end else begin
      if (rd_sample) stage[sweep_idx] <= rtc_ad_in;
      if (sweep_last) begin
        for (int i = 0; i < 9; i++) shd[i] <= stage[i];
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 9; i++) shd[i] <= 8'h00;
    end else if (rd_sample) begin
      shd[sweep_idx] <= rtc_ad_in;
    end
  end
`endif

  assign seg   = shd[0];
  assign min   = shd[1];
  assign hora  = shd[2];
  assign dia   = shd[3];
  assign mes   = shd[4];
  assign ano   = shd[5];
  assign cseg  = shd[6];
  assign cmin  = shd[7];
  assign chora = shd[8];

endmodule

// File: tb/tb_rtc_bus_sched.sv
// tb/tb_rtc_bus_sched.sv - directed self-checking bench for rtc_bus_sched (T_PHASE=2, REFRESH_CYCLES=64)
module tb_rtc_bus_sched;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_req;
  logic [7:0] wr_addr, wr_data;
  logic       wr_busy, wr_overrun;
  logic       rtc_cs_n, rtc_ad_sel, rtc_rd_n, rtc_wr_n, rtc_ad_oe;
  logic [7:0] rtc_ad_out, rtc_ad_in;
  logic [7:0] seg, min, hora, dia, mes, ano, cseg, cmin, chora;
  logic       sweep_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  localparam logic [71:0] SHADOW_EXP = 72'h31_32_33_34_35_36_51_52_53;

  rtc_bus_sched #(.T_PHASE(2), .REFRESH_CYCLES(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_busy(wr_busy), .wr_overrun(wr_overrun),
    .rtc_cs_n(rtc_cs_n), .rtc_ad_sel(rtc_ad_sel), .rtc_rd_n(rtc_rd_n), .rtc_wr_n(rtc_wr_n),
    .rtc_ad_out(rtc_ad_out), .rtc_ad_oe(rtc_ad_oe), .rtc_ad_in(rtc_ad_in),
    .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .ano(ano),
    .cseg(cseg), .cmin(cmin), .chora(chora), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  // RTC chip model: remembers the latched address and answers with address + 0x10.
  logic [7:0] model_addr = 8'h00;
  always @(posedge clk)
    if (!rtc_cs_n && rtc_ad_sel && rtc_ad_oe) model_addr <= rtc_ad_out;
  assign rtc_ad_in = model_addr + 8'h10;

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset_n = 1'b0;
    wr_req  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad_sel, rtc_ad_oe, wr_busy, wr_overrun, sweep_done} !== 8'b1110_0000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 11100000",
               {rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad_sel, rtc_ad_oe, wr_busy, wr_overrun, sweep_done});
    end
    checks++;
    if ({rtc_ad_out, seg, min, hora, dia, mes, ano, cseg, cmin, chora} !== 80'h0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", {rtc_ad_out, seg, min, hora, dia, mes, ano, cseg, cmin, chora});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_first_sweep;
    int pulses = 0;
    int at = 0;
    run_to(64);
    checks++;
    if (rtc_cs_n !== 1'b1) begin
      errors++;
      $display("FAIL idle_before_refresh cs_n got %b want 1", rtc_cs_n);
    end
    tick();
    checks++;
    if ({rtc_cs_n, rtc_ad_sel, rtc_ad_out} !== {1'b0, 1'b1, 8'h21}) begin
      errors++;
      $display("FAIL sweep_first_addr got cs_n=%b sel=%b ad=%h want 0 1 21", rtc_cs_n, rtc_ad_sel, rtc_ad_out);
    end
    while (cyc < 160) begin
      tick();
      if (sweep_done) begin
        pulses++;
        at = cyc;
      end
      if (cyc == 100) begin
        checks++;
`ifdef RTC_SNAPSHOT_EN
        if (seg !== 8'h00) begin
          errors++;
          $display("FAIL snapshot_hold seg got %h want 00", seg);
        end
`else
        if (seg !== 8'h31) begin
          errors++;
          $display("FAIL early_seg got %h want 31", seg);
        end
`endif
      end
      if (cyc == 144) begin
        checks++;
`ifdef RTC_SNAPSHOT_EN
        if ({seg, chora} !== 16'h0000) begin
          errors++;
          $display("FAIL snapshot_before_done got %h want 0000", {seg, chora});
        end
`else
        if ({seg, chora} !== 16'h3153) begin
          errors++;
          $display("FAIL live_before_done got %h want 3153", {seg, chora});
        end
`endif
      end
      if (cyc == 145) begin
        checks++;
        if ({seg, min, hora, dia, mes, ano, cseg, cmin, chora} !== SHADOW_EXP) begin
          errors++;
          $display("FAIL sweep1_shadows got %h want %h", {seg, min, hora, dia, mes, ano, cseg, cmin, chora}, SHADOW_EXP);
        end
      end
    end
    checks++;
    if (pulses != 1 || at != 145) begin
      errors++;
      $display("FAIL sweep_done_pulse got count=%0d at=%0d want count=1 at=145", pulses, at);
    end
  endtask

  task automatic test_write_idle;
    int busy_cnt = 0;
    do_reset();
    wr_addr = 8'h22;
    wr_data = 8'h45;
    wr_req  = 1'b1;
    while (cyc < 20) begin
      tick();
      wr_req = 1'b0;
      if (wr_busy) busy_cnt++;
      if (cyc == 2) begin
        checks++;
        if ({rtc_cs_n, rtc_ad_sel, rtc_rd_n, rtc_wr_n, rtc_ad_oe, rtc_ad_out} !== {5'b01101, 8'h22}) begin
          errors++;
          $display("FAIL wr_addr_phase got %b_%h want 01101_22",
                   {rtc_cs_n, rtc_ad_sel, rtc_rd_n, rtc_wr_n, rtc_ad_oe}, rtc_ad_out);
        end
      end
      if (cyc == 6) begin
        checks++;
        if ({rtc_cs_n, rtc_ad_sel, rtc_rd_n, rtc_wr_n, rtc_ad_oe, rtc_ad_out} !== {5'b00101, 8'h45}) begin
          errors++;
          $display("FAIL wr_data_phase got %b_%h want 00101_45",
                   {rtc_cs_n, rtc_ad_sel, rtc_rd_n, rtc_wr_n, rtc_ad_oe}, rtc_ad_out);
        end
      end
      if (cyc == 10) begin
        // last busy cycle: this request must be dropped
        wr_addr = 8'h26;
        wr_data = 8'h77;
        wr_req  = 1'b1;
      end
    end
    checks++;
    if (busy_cnt != 10) begin
      errors++;
      $display("FAIL wr_busy_len got %0d want 10", busy_cnt);
    end
    checks++;
    if (wr_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_on_fall got %b want 1", wr_overrun);
    end
    checks++;
    if (seg !== 8'h00) begin
      errors++;
      $display("FAIL write_no_shadow seg got %h want 00", seg);
    end
  endtask

  task automatic test_overrun;
    do_reset();
    wr_addr = 8'h25;
    wr_data = 8'h99;
    wr_req  = 1'b1;
    tick();
    wr_req = 1'b0;
    checks++;
    if ({wr_busy, wr_overrun} !== 2'b10) begin
      errors++;
      $display("FAIL ovr_first_accept got %b want 10", {wr_busy, wr_overrun});
    end
    tick();
    wr_addr = 8'h26;
    wr_data = 8'h11;
    wr_req  = 1'b1;
    tick();
    wr_req = 1'b0;
    checks++;
    if (wr_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set got %b want 1", wr_overrun);
    end
    run_to(6);
    checks++;
    if ({rtc_wr_n, rtc_ad_oe, rtc_ad_out} !== {2'b01, 8'h99}) begin
      errors++;
      $display("FAIL ovr_first_data got wr_n=%b oe=%b ad=%h want 0 1 99", rtc_wr_n, rtc_ad_oe, rtc_ad_out);
    end
    run_to(40);
    checks++;
    if (wr_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky got %b want 1", wr_overrun);
    end
  endtask

  task automatic test_write_during_sweep;
    do_reset();
    run_to(92);
    checks++;
    if ({rtc_cs_n, rtc_ad_sel, rtc_ad_out} !== {2'b01, 8'h24}) begin
      errors++;
      $display("FAIL sweep_idx3_addr got cs_n=%b sel=%b ad=%h want 0 1 24", rtc_cs_n, rtc_ad_sel, rtc_ad_out);
    end
    wr_addr = 8'h10;
    wr_data = 8'hA5;
    wr_req  = 1'b1;
    tick();
    wr_req = 1'b0;
    run_to(101);
    checks++;
    if ({rtc_ad_sel, rtc_ad_oe, rtc_ad_out} !== {2'b11, 8'h10}) begin
      errors++;
      $display("FAIL mid_wr_addr got sel=%b oe=%b ad=%h want 1 1 10", rtc_ad_sel, rtc_ad_oe, rtc_ad_out);
    end
    run_to(105);
    checks++;
    if ({rtc_wr_n, rtc_ad_oe, rtc_ad_out} !== {2'b01, 8'hA5}) begin
      errors++;
      $display("FAIL mid_wr_data got wr_n=%b oe=%b ad=%h want 0 1 a5", rtc_wr_n, rtc_ad_oe, rtc_ad_out);
    end
    run_to(110);
    checks++;
    if ({rtc_ad_sel, rtc_ad_out} !== {1'b1, 8'h25}) begin
      errors++;
      $display("FAIL resume_idx4 got sel=%b ad=%h want 1 25", rtc_ad_sel, rtc_ad_out);
    end
    while (!sweep_done && cyc < 300) tick();
    checks++;
    if (cyc != 154) begin
      errors++;
      $display("FAIL resumed_sweep_done got cycle %0d want 154", cyc);
    end
    checks++;
    if ({seg, min, hora, dia, mes, ano, cseg, cmin, chora} !== SHADOW_EXP) begin
      errors++;
      $display("FAIL resumed_shadows got %h want %h", {seg, min, hora, dia, mes, ano, cseg, cmin, chora}, SHADOW_EXP);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    run_to(96);
    checks++;
    if ({rtc_cs_n, rtc_rd_n, rtc_ad_oe} !== 3'b000) begin
      errors++;
      $display("FAIL pre_reset_read got %b want 000", {rtc_cs_n, rtc_rd_n, rtc_ad_oe});
    end
`ifndef RTC_SNAPSHOT_EN
    checks++;
    if (seg !== 8'h31) begin
      errors++;
      $display("FAIL pre_reset_seg got %h want 31", seg);
    end
`endif
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad_oe, seg} !== {4'b1110, 8'h00}) begin
      errors++;
      $display("FAIL async_abort got %b_%h want 1110_00", {rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad_oe}, seg);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    run_to(65);
    checks++;
    if ({rtc_cs_n, rtc_ad_sel, rtc_ad_out} !== {2'b01, 8'h21}) begin
      errors++;
      $display("FAIL restart_idx0 got cs_n=%b sel=%b ad=%h want 0 1 21", rtc_cs_n, rtc_ad_sel, rtc_ad_out);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    wr_req  = 1'b0;
    wr_addr = 8'h00;
    wr_data = 8'h00;
    test_reset();
    test_first_sweep();
    test_write_idle();
    test_overrun();
    test_write_during_sweep();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
